// File: rtl/stg_pkg.sv
// ---------------------------------------------------------------------------
// stg_pkg
//   Shared playfield constants for the STG blocks (boss, player, player shots):
//   playfield size, boss and shot hitbox half-extents, colours, the signed
//   coordinate type used for bounds arithmetic and the hit-pulse FSM states.
//   No ports (package).
// ---------------------------------------------------------------------------
package stg_pkg;

  localparam int MAX_X = 384;
  localparam int MAX_Y = 448;

  // Boss hitbox relative to its centre: x in [bx-31, bx+32], y in [by-47, by+48]
  localparam int BOSS_HW_L = 31;
  localparam int BOSS_HW_R = 32;
  localparam int BOSS_HH_T = 47;
  localparam int BOSS_HH_B = 48;

  // Shot box relative to its anchor: x in [sx-1, sx+2], y in [sy-3, sy+4]
  localparam int SHOT_HW_L = 1;
  localparam int SHOT_HW_R = 2;
  localparam int SHOT_HH_T = 3;
  localparam int SHOT_HH_B = 4;

  // Horizontal offset of each shot in twin-shot mode
  localparam int DUAL_OFFSET = 8;

  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_YELLOW = 12'hFF0;

  // Box edges near 0 would wrap in 10-bit unsigned; compare in signed 12 bits
  typedef logic signed [11:0] coord_t;

  typedef enum logic [1:0] {
    HIT_IDLE,
    HIT_PULSE,
    HIT_GAP
  } hit_state_e;

  function automatic coord_t toCoord(input logic [9:0] v);
    return coord_t'({2'b00, v});
  endfunction

  // Closed intervals [aLo,aHi] and [bLo,bHi] share at least one point
  function automatic logic spanOverlap(input coord_t aLo, input coord_t aHi,
                                       input coord_t bLo, input coord_t bHi);
    return (aLo <= bHi) && (aHi >= bLo);
  endfunction

endpackage

// File: rtl/shot_slot.sv
// ---------------------------------------------------------------------------
// shot_slot
//   One bullet slot of the player shot pool. Holds active/sx/sy, moves the
//   shot up on a tick, retires it off the top or on a boss collision, accepts
//   a new shot on load_i and reports whether it covers the current pixel.
// Ports
//   clk_i, reset_i      clock, synchronous active-high reset
//   tick_i              movement tick
//   load_i              spawn a shot at (load_x_i, load_y_i)
//   boss_x_i/boss_y_i   boss centre;  boss_alive_i enables collisions
//   pix_x_i/pix_y_i     current VGA pixel
//   active_o            slot still occupied after this cycle's move/collide
//   hit_o               this slot collides with the boss on this tick
//   cover_o             live shot covers (pix_x_i, pix_y_i)
// ---------------------------------------------------------------------------
module shot_slot
  import stg_pkg::*;
#(
  parameter int SPEED = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [9:0] load_x_i,
  input  logic [9:0] load_y_i,
  input  logic [9:0] boss_x_i,
  input  logic [9:0] boss_y_i,
  input  logic       boss_alive_i,
  input  logic [9:0] pix_x_i,
  input  logic [9:0] pix_y_i,
  output logic       active_o,
  output logic       hit_o,
  output logic       cover_o
);

  localparam logic [9:0] SPEED_V = 10'(SPEED);

  logic       active_q, active_d;
  logic [9:0] sx_q, sx_d;
  logic [9:0] sy_q, sy_d;

  logic       exitTop;
  logic [9:0] movedY;
  logic       overlap;
  coord_t     sxC, syC, myC, bxC, byC, pxC, pyC;

  // Move first, then collide using the moved position
  always_comb begin
    exitTop = sy_q < SPEED_V;
    movedY  = sy_q - SPEED_V;
    sxC     = toCoord(sx_q);
    syC     = toCoord(sy_q);
    myC     = toCoord(movedY);
    bxC     = toCoord(boss_x_i);
    byC     = toCoord(boss_y_i);
    pxC     = toCoord(pix_x_i);
    pyC     = toCoord(pix_y_i);
    overlap = spanOverlap(sxC - coord_t'(SHOT_HW_L), sxC + coord_t'(SHOT_HW_R),
                          bxC - coord_t'(BOSS_HW_L), bxC + coord_t'(BOSS_HW_R)) &&
              spanOverlap(myC - coord_t'(SHOT_HH_T), myC + coord_t'(SHOT_HH_B),
                          byC - coord_t'(BOSS_HH_T), byC + coord_t'(BOSS_HH_B));
    hit_o    = tick_i && active_q && !exitTop && boss_alive_i && overlap;
    active_o = active_q && !(tick_i && (exitTop || hit_o));
    cover_o  = active_q &&
               spanOverlap(pxC, pxC, sxC - coord_t'(SHOT_HW_L), sxC + coord_t'(SHOT_HW_R)) &&
               spanOverlap(pyC, pyC, syC - coord_t'(SHOT_HH_T), syC + coord_t'(SHOT_HH_B));
  end

  // A load only ever targets a slot that is free after move/collide
  always_comb begin
    active_d = active_o;
    sx_d     = sx_q;
    sy_d     = (tick_i && active_o) ? movedY : sy_q;
    if (load_i) begin
      active_d = 1'b1;
      sx_d     = load_x_i;
      sy_d     = load_y_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
      sx_q     <= '0;
      sy_q     <= '0;
    end else begin
      active_q <= active_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
    end
  end

endmodule

// File: rtl/player_shot_ctrl.sv
// ---------------------------------------------------------------------------
// player_shot_ctrl
//   Player shot pool: spawns bullets while fire is held (with a cooldown in
//   ticks), moves them upward each tick, counts boss hits and replays them as
//   spaced is_hit pulses. Also provides shot pixel coverage/colour to the mixer.
// Ports
//   clk, reset             clock, synchronous active-high reset
//   fire                   debounced fire level
//   player_x, player_y     player centre
//   boss_x, boss_y         boss centre;  boss_alive gates collisions/pulses
//   x, y                   current VGA pixel
//   shot_on, rgb_out       combinational shot coverage and colour
//   is_hit                 one-cycle pulse per hit, pulses at least 2 cycles apart
//   hit_count              saturating hit total since reset
// Build option
//   DUAL_SHOT_EN: each spawn loads two slots at player_x-8 and player_x+8
//   (left only when just one slot is free).
// ---------------------------------------------------------------------------
module player_shot_ctrl
  import stg_pkg::*;
#(
  parameter int          N_SHOTS  = 8,
  parameter int          SPEED    = 4,
  parameter int          TICK_MAX = 400000,
  parameter int          COOLDOWN = 6,
  parameter int          SPAWN_DY = 16,
  parameter logic [11:0] SHOT_RGB = 12'hFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  boss_x,
  input  logic [9:0]  boss_y,
  input  logic        boss_alive,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        shot_on,
  output logic [11:0] rgb_out,
  output logic        is_hit,
  output logic [7:0]  hit_count
);

  localparam int TW = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);
  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam int IW = $clog2(N_SHOTS);
  localparam logic [9:0] SPAWN_DY_V = 10'(SPAWN_DY);

  logic [TW-1:0]      tickCnt_q, tickCnt_d;
  logic               tick;
  logic [CW-1:0]      cooldown_q, cooldown_d;
  logic [N_SHOTS-1:0] slotActive, slotHit, slotCover, slotLoad;
  logic               haveFirst;
  logic [IW-1:0]      firstIdx;
  logic               spawn;
  logic [9:0]         spawnY;
  logic [4:0]         newHits, hitTotal;
  logic [5:0]         hitSum;
  hit_state_e         state_q;
  logic [4:0]         pending_q;
  logic               isHit_q;
  logic [7:0]         hitCount_q;
`ifdef DUAL_SHOT_EN
  logic               haveSecond;
  logic [IW-1:0]      secondIdx;
  logic [9:0]         leftX, rightX;
`endif

  always_comb begin
    tick      = (tickCnt_q == TW'(TICK_MAX));
    tickCnt_d = tick ? '0 : tickCnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) tickCnt_q <= '0;
    else       tickCnt_q <= tickCnt_d;
  end

  // Lowest free slots, judged after this tick's retirements
  always_comb begin
    haveFirst = 1'b0;
    firstIdx  = '0;
`ifdef DUAL_SHOT_EN
    haveSecond = 1'b0;
    secondIdx  = '0;
`endif
    for (int i = 0; i < N_SHOTS; i++) begin
      if (!slotActive[i]) begin
        if (!haveFirst) begin
          haveFirst = 1'b1;
          firstIdx  = IW'(i);
        end
`ifdef DUAL_SHOT_EN
        else if (!haveSecond) begin
          haveSecond = 1'b1;
          secondIdx  = IW'(i);
        end
`endif
      end
    end
  end

  always_comb begin
    spawn  = tick && fire && (cooldown_q == '0) && haveFirst;
    spawnY = (player_y < SPAWN_DY_V) ? 10'd0 : player_y - SPAWN_DY_V;
`ifdef DUAL_SHOT_EN
    leftX  = (player_x < 10'(DUAL_OFFSET)) ? 10'd0 : player_x - 10'(DUAL_OFFSET);
    rightX = player_x + 10'(DUAL_OFFSET);
`endif
  end

  // A full pool leaves the cooldown untouched, so fire retries every tick
  always_comb begin
    cooldown_d = cooldown_q;
    if (tick) begin
      if (spawn)                   cooldown_d = CW'(COOLDOWN);
      else if (cooldown_q != '0)   cooldown_d = cooldown_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cooldown_q <= '0;
    else       cooldown_q <= cooldown_d;
  end

  for (genvar g = 0; g < N_SHOTS; g++) begin : g_slot
    logic       isFirst, isSecond;
    logic [9:0] loadX;
    assign isFirst = haveFirst && (firstIdx == IW'(g));
`ifdef DUAL_SHOT_EN
    assign isSecond = haveSecond && (secondIdx == IW'(g));
    assign loadX    = isSecond ? rightX : leftX;
`else
    assign isSecond = 1'b0;
    assign loadX    = player_x;
`endif
    assign slotLoad[g] = spawn && (isFirst || isSecond);

    shot_slot #(.SPEED(SPEED)) u_slot (
      .clk_i       (clk),
      .reset_i     (reset),
      .tick_i      (tick),
      .load_i      (slotLoad[g]),
      .load_x_i    (loadX),
      .load_y_i    (spawnY),
      .boss_x_i    (boss_x),
      .boss_y_i    (boss_y),
      .boss_alive_i(boss_alive),
      .pix_x_i     (x),
      .pix_y_i     (y),
      .active_o    (slotActive[g]),
      .hit_o       (slotHit[g]),
      .cover_o     (slotCover[g])
    );
  end

  // Hits of this tick merged with the backlog, saturating the 5-bit counter
  always_comb begin
    newHits = '0;
    for (int i = 0; i < N_SHOTS; i++) newHits = newHits + 5'(slotHit[i]);
    hitSum   = {1'b0, pending_q} + {1'b0, newHits};
    hitTotal = (hitSum > 6'd31) ? 5'd31 : hitSum[4:0];
  end

  // Pulse FSM: PULSE is always followed by a quiet cycle before the next hit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HIT_IDLE;
      pending_q  <= '0;
      isHit_q    <= 1'b0;
      hitCount_q <= '0;
    end else if (!boss_alive) begin
      state_q   <= HIT_IDLE;
      pending_q <= '0;
      isHit_q   <= 1'b0;
    end else begin
      case (state_q)
        HIT_PULSE: begin
          state_q   <= HIT_GAP;
          isHit_q   <= 1'b0;
          pending_q <= hitTotal;
        end
        default: begin
          if (hitTotal != '0) begin
            state_q   <= HIT_PULSE;
            isHit_q   <= 1'b1;
            pending_q <= hitTotal - 1'b1;
            if (hitCount_q != 8'hFF) hitCount_q <= hitCount_q + 1'b1;
          end else begin
            state_q   <= HIT_IDLE;
            isHit_q   <= 1'b0;
            pending_q <= '0;
          end
        end
      endcase
    end
  end

  assign is_hit    = isHit_q;
  assign hit_count = hitCount_q;
  assign shot_on   = |slotCover;
  assign rgb_out   = shot_on ? SHOT_RGB : RGB_BLACK;

endmodule

// File: tb/tb_player_shot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_shot_ctrl
//   Self-checking bench for player_shot_ctrl with a short tick period. A
//   behavioural model of the shot pool (arrays of shots, a pending-hit count
//   and the last pulse) runs in lock step and is compared every cycle.
// ---------------------------------------------------------------------------
module tb_player_shot_ctrl;

  localparam int          NS   = 8;
  localparam int          SPD  = 4;
  localparam int          TM   = 3;
  localparam int          CD   = 6;
  localparam int          SDY  = 16;
  localparam logic [11:0] SRGB = 12'hFF0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fire = 1'b0;
  logic [9:0]  player_x = '0, player_y = '0, boss_x = '0, boss_y = '0;
  logic        boss_alive = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        shot_on;
  logic [11:0] rgb_out;
  logic        is_hit;
  logic [7:0]  hit_count;

  int errors = 0;
  int checks = 0;

  // Model state
  bit mAct[NS];
  int mSx[NS];
  int mSy[NS];
  int mCnt, mCd, mPend, mHc;
  bit mHit;

  always #5 clk = ~clk;

  player_shot_ctrl #(
    .N_SHOTS(NS), .SPEED(SPD), .TICK_MAX(TM), .COOLDOWN(CD),
    .SPAWN_DY(SDY), .SHOT_RGB(SRGB)
  ) dut (
    .clk(clk), .reset(reset), .fire(fire),
    .player_x(player_x), .player_y(player_y),
    .boss_x(boss_x), .boss_y(boss_y), .boss_alive(boss_alive),
    .x(x), .y(y),
    .shot_on(shot_on), .rgb_out(rgb_out),
    .is_hit(is_hit), .hit_count(hit_count)
  );

  function automatic bit boxHit(int sx, int sy, int bx, int by);
    return (sx - 1 <= bx + 32) && (sx + 2 >= bx - 31) &&
           (sy - 3 <= by + 48) && (sy + 4 >= by - 47);
  endfunction

  function automatic bit modelCover(int px, int py);
    bit c = 0;
    for (int i = 0; i < NS; i++)
      if (mAct[i] && px >= mSx[i] - 1 && px <= mSx[i] + 2 && py >= mSy[i] - 3 && py <= mSy[i] + 4)
        c = 1;
    return c;
  endfunction

  // One clock of the game rules, using the inputs the DUT sees at this edge
  task automatic modelClock();
    int  newHits;
    int  tot;
    int  px;
    int  py;
    bit  tick;
    int  freeQ[$];
    if (reset) begin
      for (int i = 0; i < NS; i++) mAct[i] = 0;
      mCnt = 0; mCd = 0; mPend = 0; mHc = 0; mHit = 0;
      return;
    end
    newHits = 0;
    tick = (mCnt == TM);
    mCnt = tick ? 0 : mCnt + 1;
    if (tick) begin
      for (int i = 0; i < NS; i++) begin
        if (mAct[i]) begin
          if (mSy[i] < SPD) mAct[i] = 0;
          else begin
            mSy[i] -= SPD;
            if (boss_alive && boxHit(mSx[i], mSy[i], int'(boss_x), int'(boss_y))) begin
              mAct[i] = 0;
              newHits++;
            end
          end
        end
      end
      for (int i = 0; i < NS; i++) if (!mAct[i]) freeQ.push_back(i);
      px = int'(player_x);
      py = (int'(player_y) < SDY) ? 0 : int'(player_y) - SDY;
      if (fire && mCd == 0 && freeQ.size() > 0) begin
`ifdef DUAL_SHOT_EN
        mAct[freeQ[0]] = 1; mSx[freeQ[0]] = (px < 8) ? 0 : px - 8; mSy[freeQ[0]] = py;
        if (freeQ.size() > 1) begin
          mAct[freeQ[1]] = 1; mSx[freeQ[1]] = px + 8; mSy[freeQ[1]] = py;
        end
`else
        mAct[freeQ[0]] = 1; mSx[freeQ[0]] = px; mSy[freeQ[0]] = py;
`endif
        mCd = CD;
      end else if (mCd > 0) mCd--;
    end
    if (!boss_alive) begin
      mPend = 0;
      mHit  = 0;
    end else begin
      tot = mPend + newHits;
      if (tot > 31) tot = 31;
      if (!mHit && tot > 0) begin
        mHit  = 1;
        mPend = tot - 1;
        if (mHc < 255) mHc++;
      end else begin
        mHit  = 0;
        mPend = tot;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelClock();
    #1;
  endtask

  task automatic applyStimulus(bit f, int px, int py, int bx, int by, bit alive);
    fire = f;
    player_x = 10'(px); player_y = 10'(py);
    boss_x = 10'(bx); boss_y = 10'(by);
    boss_alive = alive;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Probe pixel: mostly around a live model shot, including its box edges
  task automatic pickProbe(output int px, output int py);
    int live[$];
    for (int i = 0; i < NS; i++) if (mAct[i]) live.push_back(i);
    if (live.size() > 0 && $urandom_range(0, 3) != 0) begin
      int k = live[$urandom_range(0, live.size() - 1)];
      px = mSx[k] + int'($urandom_range(0, 5)) - 2;
      py = mSy[k] + int'($urandom_range(0, 9)) - 4;
    end else begin
      px = int'($urandom_range(0, 450));
      py = int'($urandom_range(0, 450));
    end
    if (px < 0) px = 0;
    if (py < 0) py = 0;
  endtask

  task automatic test_reset();
    applyStimulus(1, 192, 400, 192, 100, 1);
    reset = 1'b1;
    step(); step(); step(); step(); step();
    x = 10'd192; y = 10'd384; #1;
    checks++; if (is_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_is_hit got=%0b want=0", is_hit); end
    checks++; if (hit_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_hit_count got=%0d want=0", hit_count); end
    checks++; if (shot_on !== 1'b0) begin errors++; $display("[TB] FAIL reset_shot_on got=%0b want=0", shot_on); end
    checks++; if (rgb_out !== 12'h000) begin errors++; $display("[TB] FAIL reset_rgb got=%h want=000", rgb_out); end
    reset = 1'b0;
  endtask

  task automatic test_spawn_cadence();
    int px, py;
    bit cov;
    applyStimulus(1, 192, 400, 0, 0, 0);
    applyReset();
    for (int s = 1; s <= 240; s++) begin
      step();
      if (s == 4) begin
        x = 10'd192; y = 10'd384; #1;
`ifndef DUAL_SHOT_EN
        checks++; if (shot_on !== 1'b1) begin errors++; $display("[TB] FAIL spawn_first_pos got=%0b want=1", shot_on); end
`endif
        x = 10'd192; y = 10'd380; #1;
        checks++; if (shot_on !== 1'b0) begin errors++; $display("[TB] FAIL spawn_above_box got=%0b want=0", shot_on); end
      end
      checks++; if (is_hit !== mHit) begin errors++; $display("[TB] FAIL spawn_is_hit s=%0d got=%0b want=%0b", s, is_hit, mHit); end
      x = 10'd192; y = 10'd384; #1;
      cov = modelCover(192, 384);
      checks++; if (shot_on !== cov) begin errors++; $display("[TB] FAIL spawn_point s=%0d got=%0b want=%0b", s, shot_on, cov); end
      pickProbe(px, py); x = 10'(px); y = 10'(py); #1;
      cov = modelCover(px, py);
      checks++; if (shot_on !== cov || rgb_out !== (cov ? SRGB : 12'h000)) begin
        errors++; $display("[TB] FAIL spawn_probe s=%0d (%0d,%0d) got=%0b/%h want=%0b", s, px, py, shot_on, rgb_out, cov);
      end
    end
  endtask

  task automatic test_boss_hit(bit alive);
    int px, py, pulses;
    bit cov;
    pulses = 0;
    applyStimulus(1, 192, 400, 192, 100, alive);
    applyReset();
    for (int s = 1; s <= 480; s++) begin
      if (s == 5) fire = 1'b0;
      step();
      if (is_hit === 1'b1) pulses++;
      checks++; if (is_hit !== mHit) begin errors++; $display("[TB] FAIL boss%0b_is_hit s=%0d got=%0b want=%0b", alive, s, is_hit, mHit); end
      checks++; if (hit_count !== 8'(mHc)) begin errors++; $display("[TB] FAIL boss%0b_count s=%0d got=%0d want=%0d", alive, s, hit_count, mHc); end
      pickProbe(px, py); x = 10'(px); y = 10'(py); #1;
      cov = modelCover(px, py);
      checks++; if (shot_on !== cov) begin errors++; $display("[TB] FAIL boss%0b_probe s=%0d (%0d,%0d) got=%0b want=%0b", alive, s, px, py, shot_on, cov); end
    end
`ifndef DUAL_SHOT_EN
    checks++; if (hit_count !== (alive ? 8'd1 : 8'd0)) begin
      errors++; $display("[TB] FAIL boss%0b_final_count got=%0d want=%0d", alive, hit_count, alive ? 1 : 0);
    end
    checks++; if (pulses != (alive ? 1 : 0)) begin
      errors++; $display("[TB] FAIL boss%0b_pulses got=%0d want=%0d", alive, pulses, alive ? 1 : 0);
    end
`endif
  endtask

  task automatic test_pool_full();
    int px, py;
    bit cov;
    applyStimulus(1, 100, 440, 300, 50, 0);
    applyReset();
    for (int s = 1; s <= 560; s++) begin
      step();
      pickProbe(px, py); x = 10'(px); y = 10'(py); #1;
      cov = modelCover(px, py);
      checks++; if (shot_on !== cov) begin errors++; $display("[TB] FAIL pool_probe s=%0d (%0d,%0d) got=%0b want=%0b", s, px, py, shot_on, cov); end
      x = 10'd100; y = 10'd424; #1;
      cov = modelCover(100, 424);
      checks++; if (shot_on !== cov) begin errors++; $display("[TB] FAIL pool_spawn_point s=%0d got=%0b want=%0b", s, shot_on, cov); end
    end
  endtask

  task automatic test_back_to_back();
    int p1, p2, pulses;
    p1 = -1; p2 = -1; pulses = 0;
    applyStimulus(1, 192, 400, 192, 100, 1);
    applyReset();
    for (int s = 1; s <= 280; s++) begin
      // Second shot spawned 28 px lower so both sit at y=356 after tick 8
      if (s == 5)  fire = 1'b0;
      if (s == 29) begin fire = 1'b1; player_y = 10'd372; end
      if (s == 33) fire = 1'b0;
      step();
      if (is_hit === 1'b1) begin
        pulses++;
        if (p1 < 0) p1 = s; else if (p2 < 0) p2 = s;
      end
      checks++; if (is_hit !== mHit) begin errors++; $display("[TB] FAIL b2b_is_hit s=%0d got=%0b want=%0b", s, is_hit, mHit); end
      checks++; if (hit_count !== 8'(mHc)) begin errors++; $display("[TB] FAIL b2b_count s=%0d got=%0d want=%0d", s, hit_count, mHc); end
    end
`ifndef DUAL_SHOT_EN
    checks++; if (p1 != 240 || p2 != 242) begin errors++; $display("[TB] FAIL b2b_pulse_cycles got=%0d,%0d want=240,242", p1, p2); end
    checks++; if (hit_count !== 8'd2 || pulses != 2) begin errors++; $display("[TB] FAIL b2b_total got=%0d/%0d want=2/2", hit_count, pulses); end
`endif
  endtask

`ifdef DUAL_SHOT_EN
  task automatic test_dual();
    applyStimulus(1, 100, 400, 0, 0, 0);
    applyReset();
    step(); step(); step(); step();
    x = 10'd92;  y = 10'd384; #1;
    checks++; if (shot_on !== 1'b1) begin errors++; $display("[TB] FAIL dual_left got=%0b want=1", shot_on); end
    x = 10'd108; y = 10'd384; #1;
    checks++; if (shot_on !== 1'b1) begin errors++; $display("[TB] FAIL dual_right got=%0b want=1", shot_on); end
    x = 10'd100; y = 10'd384; #1;
    checks++; if (shot_on !== 1'b0) begin errors++; $display("[TB] FAIL dual_centre got=%0b want=0", shot_on); end
  endtask
`endif

  task automatic test_random();
    int px, py;
    bit cov;
    applyReset();
    for (int s = 1; s <= 3000; s++) begin
      if (s % 40 == 1)
        applyStimulus(1, int'($urandom_range(20, 360)), int'($urandom_range(0, 440)),
                      int'($urandom_range(0, 400)), int'($urandom_range(0, 300)),
                      $urandom_range(0, 7) != 0);
      fire = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 599) == 0);
      step();
      reset = 1'b0;
      checks++; if (is_hit !== mHit) begin errors++; $display("[TB] FAIL rand_is_hit s=%0d got=%0b want=%0b", s, is_hit, mHit); end
      checks++; if (hit_count !== 8'(mHc)) begin errors++; $display("[TB] FAIL rand_count s=%0d got=%0d want=%0d", s, hit_count, mHc); end
      pickProbe(px, py); x = 10'(px); y = 10'(py); #1;
      cov = modelCover(px, py);
      checks++; if (shot_on !== cov || rgb_out !== (cov ? SRGB : 12'h000)) begin
        errors++; $display("[TB] FAIL rand_probe s=%0d (%0d,%0d) got=%0b/%h want=%0b", s, px, py, shot_on, rgb_out, cov);
      end
    end
  endtask

  initial begin
    $display("[TB] player_shot_ctrl bench start");
    test_reset();
    test_spawn_cadence();
    test_boss_hit(1'b1);
    test_boss_hit(1'b0);
    test_pool_full();
    test_back_to_back();
`ifdef DUAL_SHOT_EN
    test_dual();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
